sar_compare_search: RTL and testbench

- Successive-approximation search engine that drives the b side of an external magnitude comparator (compare8 style).
- Consumes the comparator's more/less outputs.
- Binary search, MSB first, recovers the unknown value applied to the comparator's a side.
- Used wherever a value is only observable through a comparator, e.g. threshold trimming and comparator-bank self-test.

---
 rtl/sar_compare_search_if.sv | 32 +++
 rtl/sar_compare_search.sv | 134 +++++++++++++
 tb/tb_sar_compare_search.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_compare_search_if.sv
// +----------------------------------------------------------------------------+
// | Module : sar_compare_search_if                                             |
// | Desc   : Request/compare/result signal bundle for sar_compare_search.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sar_compare_search_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             more;
    logic             less;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    // slave: the search engine; master: the requester plus comparator
    modport slave (
        input  start, more, less,
        output probe, busy, done, result, err
    );

    modport master (
        output start, more, less,
        input  probe, busy, done, result, err
    );
endinterface

`default_nettype wire

// File: rtl/sar_compare_search.sv
// +----------------------------------------------------------------------------+
// | Module : sar_compare_search                                                |
// | Desc   : MSB-first successive-approximation search behind a comparator.    |
// |          Optional macro SAR_EARLY_EXIT_EN finishes on probe == target.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sar_compare_search #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    sar_compare_search_if.slave   bus
);

    localparam int                 c_IDX_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_MSB     = c_ONE << (WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_probe,  w_probe_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic [WIDTH-1:0]   r_acc,    w_acc_nxt;
    logic [c_IDX_W-1:0] r_idx,    w_idx_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_err,    w_err_nxt;
    logic [WIDTH-1:0]   w_acc_upd;
    logic               w_early;

`ifdef SAR_EARLY_EXIT_EN
    assign w_early = !bus.more && !bus.less;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_probe  <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_probe  <= w_probe_nxt;
            r_result <= w_result_nxt;
            r_acc    <= w_acc_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_probe_nxt  = r_probe;
        w_result_nxt = r_result;
        w_acc_nxt    = r_acc;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;

        // A contradictory more&less sample has less set, so the bit clears.
        w_acc_upd        = r_acc;
        w_acc_upd[r_idx] = !bus.less;

        case (r_state)
            S_IDLE: begin
                w_probe_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_SEARCH;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = c_IDX_TOP;
                    w_probe_nxt = c_MSB;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end

            S_SEARCH: begin
                if (bus.more && bus.less) begin
                    w_err_nxt = 1'b1;
                end
                if (w_early) begin
                    w_state_nxt  = S_IDLE;
                    w_result_nxt = r_probe;
                    w_done_nxt   = 1'b1;
                    w_probe_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                end else if (r_idx == '0) begin
                    w_state_nxt  = S_IDLE;
                    w_result_nxt = w_acc_upd;
                    w_acc_nxt    = w_acc_upd;
                    w_done_nxt   = 1'b1;
                    w_probe_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_acc_nxt   = w_acc_upd;
                    w_idx_nxt   = r_idx - c_IDX_ONE;
                    w_probe_nxt = w_acc_upd | (c_ONE << (r_idx - c_IDX_ONE));
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.probe  = r_probe;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_compare_search.sv
// +----------------------------------------------------------------------------+
// | Module : tb_sar_compare_search                                             |
// | Desc   : Scoreboard bench for sar_compare_search with a modelled comparator.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sar_compare_search;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] target;
    logic       force_both;

    int n_vec;
    int n_err;

    logic [7:0] q_res[$];
    int         q_lat[$];
    logic [7:0] probe_log[$];
    int         busy_gap;

    sar_compare_search_if #(.WIDTH(W)) bus ();

    sar_compare_search #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational magnitude comparator on the a=target, b=probe pair
    assign bus.more = force_both | (target > bus.probe);
    assign bus.less = force_both | (target < bus.probe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] t, input bit ff,
                                  output logic [7:0] res, output int lat);
        logic [7:0] acc;
        logic [7:0] p;
        bit         both;
        acc = 8'h00;
        lat = W;
        for (int i = W - 1; i >= 0; i--) begin
            p    = acc | (8'h01 << i);
            both = ff && (i == W - 1);
`ifdef SAR_EARLY_EXIT_EN
            if (!both && t == p) begin
                res = p;
                lat = W - i;
                return;
            end
`endif
            if (!both && t >= p) acc = p;
        end
        res = acc;
    endfunction

    // Called at posedge+1 while idle; leaves the caller at posedge+1 after the accepting edge
    task automatic launch(input logic [7:0] t, input bit ff);
        logic [7:0] r;
        int         l;
        target = t;
        model(t, ff, r, l);
        q_res.push_back(r);
        q_lat.push_back(l);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, input bit ff, output int cyc, output bit to);
        probe_log.delete();
        busy_gap = 0;
        cyc      = 0;
        to       = 1'b1;
        if (ff) force_both = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            probe_log.push_back(bus.probe);
            if (!bus.busy) busy_gap++;
            if (k == poke_at) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            force_both = 1'b0;
            if (bus.done) begin
                cyc = k;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({bus.probe, bus.result, bus.busy, bus.done, bus.err} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_state: got probe=%h result=%h busy=%b done=%b err=%b, want all zero",
                     bus.probe, bus.result, bus.busy, bus.done, bus.err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_a5;
        logic [7:0] exp_p[8];
        int cyc;
        bit to;
        logic [7:0] er;
        int el;
        exp_p = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        launch(8'hA5, 1'b0);
        wait_done(0, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || cyc != el) begin
            n_err++;
            $display("FAIL a5_latency: got %0d (timeout=%b), want %0d", cyc, to, el);
        end
        n_vec++;
        if (bus.result !== er || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL a5_result: got %h err=%b, want %h err=0", bus.result, bus.err, er);
        end
        n_vec++;
        if (probe_log.size() != 8) begin
            n_err++;
            $display("FAIL a5_probe_count: got %0d, want 8", probe_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (probe_log[i] !== exp_p[i]) begin
                    n_err++;
                    $display("FAIL a5_probe[%0d]: got %h, want %h", i, probe_log[i], exp_p[i]);
                    break;
                end
            end
        end
        n_vec++;
        if (bus.busy !== 1'b0 || busy_gap != 0) begin
            n_err++;
            $display("FAIL a5_busy: got busy_at_done=%b gaps=%0d, want 0 and 0", bus.busy, busy_gap);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.done !== 1'b0 || bus.probe !== 8'h00 || bus.result !== 8'hA5) begin
            n_err++;
            $display("FAIL a5_after_done: got done=%b probe=%h result=%h, want 0 00 a5",
                     bus.done, bus.probe, bus.result);
        end
    endtask

    task automatic test_extremes;
        logic [7:0] tv[2];
        int cyc;
        bit to;
        logic [7:0] er;
        int el;
        tv = '{8'h00, 8'hFF};
        for (int j = 0; j < 2; j++) begin
            launch(tv[j], 1'b0);
            wait_done(0, 1'b0, cyc, to);
            er = q_res.pop_front();
            el = q_lat.pop_front();
            n_vec++;
            if (to || cyc != el || el != 8) begin
                n_err++;
                $display("FAIL extreme_latency %h: got %0d, want 8", tv[j], cyc);
            end
            n_vec++;
            if (bus.result !== er || er !== tv[j]) begin
                n_err++;
                $display("FAIL extreme_result: got %h, want %h", bus.result, tv[j]);
            end
            if (tv[j] == 8'h00) begin
                n_vec++;
                for (int i = 0; i < probe_log.size(); i++) begin
                    if (probe_log[i] !== (8'h80 >> i)) begin
                        n_err++;
                        $display("FAIL zero_probe[%0d]: got %h, want %h", i, probe_log[i], 8'h80 >> i);
                        break;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignored_start;
        int cyc;
        int extra;
        bit to;
        logic [7:0] er;
        int el;
        launch(8'h3C, 1'b0);
        wait_done(3, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || cyc != el || bus.result !== er) begin
            n_err++;
            $display("FAIL ignore_start: got lat=%0d result=%h, want lat=%0d result=%h",
                     cyc, bus.result, el, er);
        end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL ignore_single_done: got %0d extra busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_err;
        int cyc;
        bit to;
        logic [7:0] er;
        int el;
        launch(8'h90, 1'b1);
        wait_done(0, 1'b1, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || bus.err !== 1'b1 || bus.result !== er || bus.result[7] !== 1'b0) begin
            n_err++;
            $display("FAIL err_flag: got err=%b result=%h, want err=1 result=%h", bus.err, bus.result, er);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b, want 1", bus.err);
        end
        launch(8'h21, 1'b0);
        n_vec++;
        if (bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b, want 0", bus.err);
        end
        wait_done(0, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || bus.result !== er || bus.err !== 1'b0) begin
            n_err++;
            $display("FAIL err_next_search: got %h err=%b, want %h err=0", bus.result, bus.err, er);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_midreset;
        int cyc;
        bit to;
        logic [7:0] er;
        int el;
        launch(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q_res.delete();
        q_lat.delete();
        n_vec++;
        if ({bus.probe, bus.result, bus.busy, bus.done, bus.err} !== 19'h0) begin
            n_err++;
            $display("FAIL midreset: got probe=%h result=%h busy=%b done=%b err=%b, want all zero",
                     bus.probe, bus.result, bus.busy, bus.done, bus.err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.probe !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_idle: got busy=%b probe=%h, want 0 00", bus.busy, bus.probe);
        end
        launch(8'h5A, 1'b0);
        wait_done(0, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || cyc != el || bus.result !== er) begin
            n_err++;
            $display("FAIL midreset_recover: got lat=%0d result=%h, want lat=%0d result=%h",
                     cyc, bus.result, el, er);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit to;
        logic [7:0] er;
        int el;
        launch(8'h80, 1'b0);
        wait_done(0, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || cyc != el || bus.result !== 8'h80 || er !== 8'h80) begin
            n_err++;
            $display("FAIL target80: got lat=%0d result=%h, want lat=%0d result=80", cyc, bus.result, el);
        end
        // Restart in the done cycle itself
        launch(8'h37, 1'b0);
        n_vec++;
        if (bus.busy !== 1'b1 || bus.probe !== 8'h80) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b probe=%h, want 1 80", bus.busy, bus.probe);
        end
        wait_done(0, 1'b0, cyc, to);
        er = q_res.pop_front();
        el = q_lat.pop_front();
        n_vec++;
        if (to || cyc != el || bus.result !== er) begin
            n_err++;
            $display("FAIL b2b_result: got lat=%0d result=%h, want lat=%0d result=%h",
                     cyc, bus.result, el, er);
        end
        for (int j = 0; j < 4; j++) begin
            launch(8'($urandom_range(0, 255)), 1'b0);
            wait_done(0, 1'b0, cyc, to);
            er = q_res.pop_front();
            el = q_lat.pop_front();
            n_vec++;
            if (to || cyc != el || bus.result !== target) begin
                n_err++;
                $display("FAIL random_%0d: got lat=%0d result=%h, want lat=%0d result=%h",
                         j, cyc, bus.result, el, target);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        target     = 8'h00;
        force_both = 1'b0;
        bus.start  = 1'b0;
        rst_n      = 1'b0;
        test_reset();
        test_a5();
        test_extremes();
        test_ignored_start();
        test_err();
        test_midreset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
